// File: rtl/cpu_io_pkg.sv
// rtl/cpu_io_pkg.sv - shared constants and FSM encoding for the CPU I/O port blocks
package cpu_io_pkg;

  localparam int CPU_DATA_W      = 32;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_REQ      = 2'b01;
  localparam logic [1:0] ST_WAIT_LOW = 2'b10;

  // Advance a FIFO pointer; DEPTH is a power of two so the natural wrap is modulo DEPTH.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1) % depth;
  endfunction

endpackage

// File: rtl/io_sync_ff.sv
// rtl/io_sync_ff.sv - multi-stage synchronizer for a single asynchronous control bit
module io_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (!clr) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/out_port_tx.sv
// rtl/out_port_tx.sv - output port: FIFO-buffered words sent over a 4-phase req/ack handshake
// Optional same-edge bypass of an empty FIFO: OUT_PORT_TX_BYPASS_EN
module out_port_tx
  import cpu_io_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int DATA_W      = CPU_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [DATA_W-1:0]          BusMuxOut,
  input  logic                       OutPortIn,
  input  logic                       ovf_clr,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_req,
  input  logic                       out_ack,
  output logic                       out_full,
  output logic                       out_empty,
  output logic                       out_overflow,
  output logic [$clog2(DEPTH):0]     out_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [1:0]        state;
  logic              ack_s;
  logic              pop;
  logic              bypass;
  logic              wr_en;

  io_sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk(clk),
    .clr(clr),
    .d  (out_ack),
    .q  (ack_s)
  );

  assign out_count = count;
  assign out_full  = (count == CW'(DEPTH));
  assign out_empty = (count == '0);

  // The head leaves the FIFO as soon as it is loaded into out_data, freeing its slot.
  assign pop = (state == ST_IDLE) && (count != '0);

`ifdef OUT_PORT_TX_BYPASS_EN
  assign bypass = (state == ST_IDLE) && (count == '0) && OutPortIn;
`else
  assign bypass = 1'b0;
`endif

  assign wr_en = OutPortIn && !out_full && !bypass;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= BusMuxOut;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= PW'(ptr_next(32'(wr_ptr), DEPTH));
      end
      if (pop) begin
        rd_ptr <= PW'(ptr_next(32'(rd_ptr), DEPTH));
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped capture sets the flag even when a clear arrives on the same edge.
  always_ff @(posedge clk) begin
    if (!clr) begin
      out_overflow <= 1'b0;
    end else if (OutPortIn && out_full) begin
      out_overflow <= 1'b1;
    end else if (ovf_clr) begin
      out_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= ST_IDLE;
      out_req  <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            out_data <= mem[rd_ptr];
            out_req  <= 1'b1;
            state    <= ST_REQ;
          end else if (bypass) begin
            out_data <= BusMuxOut;
            out_req  <= 1'b1;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_s) begin
            out_req <= 1'b0;
            state   <= ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (!ack_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          out_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_tx.sv
// tb/tb_out_port_tx.sv - self-checking bench for out_port_tx: vector table, directed sequences, random vs model
module tb_out_port_tx;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int S     = 2;

  logic          clk = 1'b0;
  logic          clr;
  logic [DW-1:0] BusMuxOut;
  logic          OutPortIn;
  logic          ovf_clr;
  logic [DW-1:0] out_data;
  logic          out_req;
  logic          out_ack;
  logic          out_full;
  logic          out_empty;
  logic          out_overflow;
  logic [2:0]    out_count;

  always #5 clk = ~clk;

  out_port_tx #(.DEPTH(DEPTH), .DATA_W(DW), .SYNC_STAGES(S)) dut (
    .clk(clk), .clr(clr), .BusMuxOut(BusMuxOut), .OutPortIn(OutPortIn),
    .ovf_clr(ovf_clr), .out_data(out_data), .out_req(out_req), .out_ack(out_ack),
    .out_full(out_full), .out_empty(out_empty), .out_overflow(out_overflow),
    .out_count(out_count)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        c, in;
    logic [31:0] d;
    logic        oc, ack;
    logic        req;
    logic [31:0] data;
    int          cnt;
    logic        full, empty, ovf;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic c, logic in, logic [31:0] d, logic oc, logic ack,
                              logic req, logic [31:0] data, int cnt,
                              logic full, logic empty, logic ovf);
    vec_t v;
    v.c = c; v.in = in; v.d = d; v.oc = oc; v.ack = ack;
    v.req = req; v.data = data; v.cnt = cnt; v.full = full; v.empty = empty; v.ovf = ovf;
    return v;
  endfunction

  // Reference model: queue of buffered words plus an abstract handshake phase.
  logic [31:0] mq[$];
  logic [31:0] exp_tx[$];
  logic [31:0] rx[$];
  bit          hist[$];
  bit          m_busy, m_drain, m_ovf, prev_req;
  logic [31:0] m_last;

  bit          dev_auto;
  int          dev_dly, dev_cnt;
  logic        ack_r;

  task automatic model_reset();
    mq.delete();
    hist.delete();
    for (int i = 0; i < S; i++) hist.push_back(1'b0);
    m_busy = 0; m_drain = 0; m_ovf = 0; m_last = '0;
  endtask

  task automatic step(input logic c, input logic in, input logic [31:0] d, input logic oc);
    bit ack_s_old, full_old, idle, byp;
    if (dev_auto) begin
      if (out_req !== ack_r) begin
        if (dev_cnt >= dev_dly) begin
          ack_r = out_req; dev_cnt = 0; dev_dly = $urandom_range(0, 4);
        end else dev_cnt++;
      end else dev_cnt = 0;
    end
    clr = c; OutPortIn = in; BusMuxOut = d; ovf_clr = oc; out_ack = ack_r;
    @(posedge clk);
    if (!c) begin
      model_reset();
    end else begin
      ack_s_old = hist.pop_front();
      hist.push_back(ack_r);
      full_old = (mq.size() == DEPTH);
      idle = !m_busy && !m_drain;
      byp = 0;
      if (in && full_old) m_ovf = 1;
      else if (oc) m_ovf = 0;
      if (idle && mq.size() > 0) begin
        m_last = mq.pop_front(); m_busy = 1; exp_tx.push_back(m_last);
      end
`ifdef OUT_PORT_TX_BYPASS_EN
      else if (idle && in) begin
        m_last = d; m_busy = 1; byp = 1; exp_tx.push_back(d);
      end
`endif
      else if (m_busy && ack_s_old) begin
        m_busy = 0; m_drain = 1;
      end else if (m_drain && !ack_s_old) begin
        m_drain = 0;
      end
      if (in && !full_old && !byp) mq.push_back(d);
    end
    #1;
    chk("req",   32'(out_req),      32'(m_busy));
    chk("data",  out_data,          m_last);
    chk("count", 32'(out_count),    32'(mq.size()));
    chk("full",  32'(out_full),     32'(mq.size() == DEPTH));
    chk("empty", 32'(out_empty),    32'(mq.size() == 0));
    chk("ovf",   32'(out_overflow), 32'(m_ovf));
    if (out_req && !prev_req) rx.push_back(out_data);
    prev_req = out_req;
  endtask

  task automatic start_seq();
    exp_tx.delete(); rx.delete();
    ack_r = 0; dev_cnt = 0; dev_dly = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic drain(input string nm);
    bit done;
    dev_auto = 1;
    done = 0;
    for (int k = 0; k < 400; k++) begin
      if (mq.size() == 0 && !m_busy && !m_drain && !ack_r) begin
        done = 1;
        break;
      end
      step(1, 0, 0, 0);
    end
    chk({nm, "_drain_done"}, 32'(done), 32'd1);
  endtask

  task automatic cmp_rx(input string nm);
    chk({nm, "_rx_len"}, 32'(rx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < rx.size() && i < exp_tx.size(); i++)
      chk({nm, "_rx_word"}, rx[i], exp_tx[i]);
  endtask

  initial begin
    clr = 0; OutPortIn = 0; BusMuxOut = '0; ovf_clr = 0; out_ack = 0;
    dev_auto = 0; ack_r = 0; prev_req = 0;
    model_reset();

    tbl[0]  = mk(0,0,32'd0,0,0,    0,32'd0,0,0,1,0);
`ifdef OUT_PORT_TX_BYPASS_EN
    tbl[1]  = mk(1,1,32'd50,0,0,   1,32'd50,0,0,1,0);
`else
    tbl[1]  = mk(1,1,32'd50,0,0,   0,32'd0,1,0,0,0);
`endif
    tbl[2]  = mk(1,0,32'd0,0,0,    1,32'd50,0,0,1,0);
    tbl[3]  = mk(1,0,32'd0,0,0,    1,32'd50,0,0,1,0);
    tbl[4]  = mk(1,0,32'd0,0,1,    1,32'd50,0,0,1,0);
    tbl[5]  = mk(1,0,32'd0,0,1,    1,32'd50,0,0,1,0);
    tbl[6]  = mk(1,0,32'd0,0,1,    0,32'd50,0,0,1,0);
    tbl[7]  = mk(1,0,32'd0,0,0,    0,32'd50,0,0,1,0);
    tbl[8]  = mk(1,0,32'd0,0,0,    0,32'd50,0,0,1,0);
    tbl[9]  = mk(1,0,32'd0,0,0,    0,32'd50,0,0,1,0);
`ifdef OUT_PORT_TX_BYPASS_EN
    tbl[10] = mk(1,1,32'd1,0,0,    1,32'd1,0,0,1,0);
`else
    tbl[10] = mk(1,1,32'd1,0,0,    0,32'd50,1,0,0,0);
`endif
    tbl[11] = mk(1,1,32'd2,0,0,    1,32'd1,1,0,0,0);
    tbl[12] = mk(1,1,32'd3,0,0,    1,32'd1,2,0,0,0);
    tbl[13] = mk(1,1,32'd4,0,0,    1,32'd1,3,0,0,0);
    tbl[14] = mk(1,1,32'd5,0,0,    1,32'd1,4,1,0,0);
    tbl[15] = mk(1,1,32'hDEAD,0,0, 1,32'd1,4,1,0,1);
    tbl[16] = mk(1,0,32'd0,1,0,    1,32'd1,4,1,0,0);
    tbl[17] = mk(1,1,32'hBEEF,1,0, 1,32'd1,4,1,0,1);
    tbl[18] = mk(0,0,32'd0,0,0,    0,32'd0,0,0,1,0);
    tbl[19] = mk(1,0,32'd0,0,1,    0,32'd0,0,0,1,0);
    tbl[20] = mk(1,0,32'd0,0,1,    0,32'd0,0,0,1,0);
    tbl[21] = mk(1,0,32'd0,0,0,    0,32'd0,0,0,1,0);

    for (int i = 0; i < 22; i++) begin
      clr = tbl[i].c; OutPortIn = tbl[i].in; BusMuxOut = tbl[i].d;
      ovf_clr = tbl[i].oc; out_ack = tbl[i].ack;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_req", i),   32'(out_req),      32'(tbl[i].req));
      chk($sformatf("tbl%0d_data", i),  out_data,          tbl[i].data);
      chk($sformatf("tbl%0d_count", i), 32'(out_count),    32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_full", i),  32'(out_full),     32'(tbl[i].full));
      chk($sformatf("tbl%0d_empty", i), 32'(out_empty),    32'(tbl[i].empty));
      chk($sformatf("tbl%0d_ovf", i),   32'(out_overflow), 32'(tbl[i].ovf));
    end

    // Burst into a stalled device, then release it.
    dev_auto = 0;
    start_seq();
    for (int w = 5; w <= 9; w++) step(1, 1, 32'(w), 0);
    step(1, 1, 32'hDEAD, 0);
    chk("burst_count", 32'(out_count), 32'd4);
    chk("burst_ovf", 32'(out_overflow), 32'd1);
    drain("burst");
    chk("burst_rx_len_const", 32'(rx.size()), 32'd5);
    for (int i = 0; i < rx.size() && i < 5; i++) chk("burst_order", rx[i], 32'(i + 5));

    // Reset while a word is in flight with two buffered.
    dev_auto = 0;
    start_seq();
    for (int w = 1; w <= 3; w++) step(1, 1, 32'(w), 0);
    chk("mid_cnt_pre", 32'(out_count), 32'd2);
    step(0, 0, 0, 0);
    chk("mid_req", 32'(out_req), 32'd0);
    chk("mid_data", out_data, 32'd0);
    ack_r = 1;
    for (int k = 0; k < 6; k++) step(1, 0, 0, 0);
    ack_r = 0;
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0);

    // Twelve words with captures overlapping pops.
    dev_auto = 1;
    start_seq();
    begin
      int nxt;
      nxt = 1;
      for (int k = 0; k < 600 && nxt <= 12; k++) begin
        if (mq.size() < DEPTH) begin
          step(1, 1, 32'(nxt), 0);
          nxt++;
        end else step(1, 0, 0, 0);
      end
      chk("wrap_all_sent", 32'(nxt), 32'd13);
    end
    drain("wrap");
    chk("wrap_rx_len_const", 32'(rx.size()), 32'd12);
    for (int i = 0; i < rx.size() && i < 12; i++) chk("wrap_order", rx[i], 32'(i + 1));

    // Randomized traffic against the model.
    dev_auto = 1;
    start_seq();
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 2) == 0),
           $urandom(), ($urandom_range(0, 15) == 0));
    end
    drain("rand");
    cmp_rx("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/out_port_tx.md
Name: out_port_tx

Overview:
- Transmit end of the CPU I/O path. Mirrors the input port that loads external data into a register.
- Captures BusMuxOut when the control unit asserts OutPortIn during an "out Ra" instruction.
- Buffers captured words in a small FIFO and drives each word to an external device over a 4-phase req/ack handshake.
- Reports full/empty to the control unit so it can stall further out instructions.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- DATA_W, 32, word width (matches bus)
- SYNC_STAGES, 2, flip-flop stages on the asynchronous out_ack input (>=2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- clr  in  1  synchronous, active-low reset
- BusMuxOut  in  DATA_W  internal bus value
- OutPortIn  in  1  capture strobe from control unit
- ovf_clr  in  1  clears sticky overflow flag
- out_data  out  DATA_W  word presented to external device
- out_req  out  1  4-phase request
- out_ack  in  1  4-phase acknowledge from device (asynchronous)
- out_full  out  1  FIFO full, control unit must stall
- out_empty  out  1  FIFO empty
- out_overflow  out  1  sticky: capture attempted while full
- out_count  out  $clog2(DEPTH)+1  words held in FIFO, excluding the word in flight

Behaviour:
- Reset (clr=0 at a rising edge):
  - out_data=0, out_req=0, out_count=0, out_empty=1, out_full=0, out_overflow=0.
  - Synchronizer flops cleared, FSM=IDLE.
  - Reset mid-handshake drops out_req next edge and discards all buffered words and the in-flight word.
- Capture:
  - At a rising edge with OutPortIn=1 and out_full=0 (registered value), BusMuxOut is written at the write pointer and count increments.
  - OutPortIn held for k cycles writes k entries. The control unit pulses it for exactly one cycle.
- Full:
  - out_full = (count==DEPTH), taken from registered count.
  - A capture while full is dropped and sets out_overflow, even if a pop happens in the same cycle.
- Overflow flag: out_overflow stays set until ovf_clr=1 at an edge. If set and clear occur in the same cycle, set wins.
- Pointers: wrap modulo DEPTH. Simultaneous write and pop leaves count unchanged.
- Synchronizer: ack_s = out_ack delayed by SYNC_STAGES cycles.
- FSM states:
  - IDLE: if count>0, pop the head into out_data, set out_req=1, go to REQ. Both registers update at the same edge, so data is stable before req rises.
  - REQ: hold out_req=1 and out_data. When ack_s=1, set out_req=0 and go to WAIT_LOW.
  - WAIT_LOW: when ack_s=0, go to IDLE.
  - out_data keeps the last transmitted word until the next pop.
- Latency: a capture at edge N gives out_req=1 after edge N+1, when the FIFO was empty and the FSM was in IDLE.
- Throughput: minimum 2*SYNC_STAGES+3 cycles per word, with the device acking immediately.
- Pop rule: a word leaves the FIFO when it is popped into out_data, so count excludes the in-flight word. A capture may land in the freed slot on the next edge.
- out_empty = (count==0).
- Illegal ack: an ack_s rising edge in IDLE is ignored.

Optional Feature:
- Macro: OUT_PORT_TX_BYPASS_EN.
- When defined:
  - If FSM=IDLE, count==0 and OutPortIn=1, BusMuxOut loads directly into out_data and out_req rises after the same edge N (latency 1 → 0 extra cycles).
  - The FIFO is not written and count stays 0.
- When undefined: all words pass through the FIFO, with the latency stated above.

Decomposition:
- Shared package cpu_io_pkg holds:
  - FSM state encoding (IDLE=2'b00, REQ=2'b01, WAIT_LOW=2'b10)
  - DATA_W default 32
  - default DEPTH and SYNC_STAGES constants
- One sub-module, io_sync_ff: a SYNC_STAGES-deep synchronizer with synchronous active-low clr, reused later on the input-port strobe.
- The FIFO stays inline.

Test Plan:
- Single word: reset, BusMuxOut=32'd50, OutPortIn pulse, device acks 3 cycles after req.
  - out_req rises 1 cycle after capture with out_data=50.
  - Falls SYNC_STAGES cycles after ack.
  - out_count returns to 0 and out_empty=1.
- Burst/full: device holds ack=0; capture 5,6,7,8,9 on consecutive cycles.
  - 5 goes in flight; 6–9 fill the FIFO, giving out_full=1 and out_count=4.
  - Releasing the device yields the order 5,6,7,8,9.
- Overflow: with the FIFO full, capture 32'hDEAD.
  - out_overflow=1, count stays 4, DEAD is never transmitted.
  - ovf_clr pulse clears the flag.
  - ovf_clr together with a new overflow keeps it at 1.
- Wrap and simultaneous events: 12 words 1..12 with a fast ack and captures coinciding with pops.
  - All 12 words received in order.
  - count never exceeds DEPTH; pointers wrap correctly.
- Reset mid-handshake: clr=0 while out_req=1 with count=2.
  - Next edge: out_req=0, count=0, out_data=0.
  - Late ack causes no transmission.
- Bypass (OUT_PORT_TX_BYPASS_EN defined): a capture of 50 into an empty, idle block gives out_req=1 and out_data=50 after the same edge, with out_count remaining 0.
